// File: rtl/cont_soma_ctrl.sv
// Start/stop sequencer: counts A to its limit, then B to its limit, then registers A+B.
// Optional threshold compare output is enabled with `define CONT_SOMA_THRESH_EN.
module cont_soma_ctrl #(
   parameter int CW = 6,
   parameter int SW = 7
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] lim_a,
   input  logic [CW-1:0] lim_b,
`ifdef CONT_SOMA_THRESH_EN
   input  logic [SW-1:0] thresh,
   output logic [0:0]    hit,
`endif
   output logic [CW-1:0] cnt_a,
   output logic [CW-1:0] cnt_b,
   output logic [SW-1:0] soma,
   output logic          busy,
   output logic          done,
   output logic [2:0]    state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN_A = 3'd1;
   localparam logic [2:0] S_RUN_B = 3'd2;
   localparam logic [2:0] S_SUM   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_a_q, cnt_a_d;
   logic [CW-1:0] cnt_b_q, cnt_b_d;
   logic [SW-1:0] soma_q, soma_d;
   logic [CW-1:0] lim_a_q, lim_a_d;
   logic [CW-1:0] lim_b_q, lim_b_d;
   logic [SW-1:0] sum_w;
`ifdef CONT_SOMA_THRESH_EN
   logic          hit_q, hit_d;
`endif

   // Zero-extended add: the carry lands in the top bit, never truncated.
   function automatic logic [SW-1:0] zext_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return SW'({1'b0, a}) + SW'({1'b0, b});
   endfunction

   assign sum_w = zext_add(cnt_a_q, cnt_b_q);

   always_comb begin
      state_d = state_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      soma_d  = soma_q;
      lim_a_d = lim_a_q;
      lim_b_d = lim_b_q;
`ifdef CONT_SOMA_THRESH_EN
      hit_d   = hit_q;
`endif
      // Abort outranks every other transition and freezes the datapath.
      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_d = S_IDLE;
               if (start) begin
                  state_d = S_RUN_A;
                  lim_a_d = lim_a;
                  lim_b_d = lim_b;
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  soma_d  = '0;
`ifdef CONT_SOMA_THRESH_EN
                  hit_d   = 1'b0;
`endif
               end
            end
            S_RUN_A: begin
               if (cnt_a_q == lim_a_q) state_d = S_RUN_B;
               else                    cnt_a_d = cnt_a_q + CW'(1);
            end
            S_RUN_B: begin
               if (cnt_b_q == lim_b_q) state_d = S_SUM;
               else                    cnt_b_d = cnt_b_q + CW'(1);
            end
            S_SUM: begin
               soma_d  = sum_w;
`ifdef CONT_SOMA_THRESH_EN
               hit_d   = (sum_w >= thresh);
`endif
               state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_IDLE;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         soma_q  <= '0;
         lim_a_q <= '0;
         lim_b_q <= '0;
`ifdef CONT_SOMA_THRESH_EN
         hit_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         soma_q  <= soma_d;
         lim_a_q <= lim_a_d;
         lim_b_q <= lim_b_d;
`ifdef CONT_SOMA_THRESH_EN
         hit_q   <= hit_d;
`endif
      end
   end

   assign cnt_a   = cnt_a_q;
   assign cnt_b   = cnt_b_q;
   assign soma    = soma_q;
   assign state_o = state_q;
   assign busy    = (state_q == S_RUN_A) || (state_q == S_RUN_B) || (state_q == S_SUM);
   assign done    = (state_q == S_DONE);
`ifdef CONT_SOMA_THRESH_EN
   assign hit     = hit_q;
`endif

endmodule

// File: tb/tb_cont_soma_ctrl.sv
// Scoreboard bench for cont_soma_ctrl: stimulus pushes expected done records, a monitor pops them.
module tb_cont_soma_ctrl;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [5:0] lim_a = '0;
   logic [5:0] lim_b = '0;
   logic [5:0] cnt_a, cnt_b;
   logic [6:0] soma;
   logic       busy, done;
   logic [2:0] state_o;
`ifdef CONT_SOMA_THRESH_EN
   logic [6:0] thresh = 7'd127;
   logic [0:0] hit;
`endif

   int unsigned cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int unsigned cyc;
      logic [6:0]  soma;
      logic [5:0]  a;
      logic [5:0]  b;
      logic        hit;
   } exp_t;
   exp_t q[$];

   cont_soma_ctrl #(.CW(6), .SW(7)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
      .lim_a(lim_a), .lim_b(lim_b),
`ifdef CONT_SOMA_THRESH_EN
      .thresh(thresh), .hit(hit),
`endif
      .cnt_a(cnt_a), .cnt_b(cnt_b), .soma(soma),
      .busy(busy), .done(done), .state_o(state_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected record.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (clr_n && done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
         end else begin
            e = q.pop_front();
            chk("done_cycle", int'(cyc), int'(e.cyc));
            chk("soma", int'(soma), int'(e.soma));
            chk("cnt_a_at_done", int'(cnt_a), int'(e.a));
            chk("cnt_b_at_done", int'(cnt_b), int'(e.b));
`ifdef CONT_SOMA_THRESH_EN
            chk("hit", int'(hit), int'(e.hit));
`endif
         end
      end
   end

   task automatic wait_empty(input int budget);
      int i = 0;
      while (q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got %0d pending, required 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_seq(input int la, input int lb, input bit exp_hit);
      exp_t e;
      @(negedge clk);
      lim_a = 6'(la);
      lim_b = 6'(lb);
      start = 1'b1;
      e.cyc = cyc + 1 + la + lb + 3;
      e.soma = 7'(la + lb);
      e.a = 6'(la);
      e.b = 6'(lb);
      e.hit = exp_hit;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
`ifdef CONT_SOMA_THRESH_EN
      chk("hit_cleared_on_start", int'(hit), 0);
`endif
      wait_empty(300);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      int ea, eb, es;
      repeat (3) @(negedge clk);
      chk("rst_state", int'(state_o), 0);
      chk("rst_cnt_a", int'(cnt_a), 0);
      chk("rst_soma", int'(soma), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      clr_n = 1'b1;
      repeat (2) @(negedge clk);

      // 3/5: per-cycle trace against a hand-written timeline
      lim_a = 6'd3; lim_b = 6'd5; start = 1'b1;
      e.cyc = cyc + 1 + 11; e.soma = 7'd8; e.a = 6'd3; e.b = 6'd5; e.hit = 1'b0;
      q.push_back(e);
      for (int t = 0; t <= 12; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (t <= 3)       es = 1;
         else if (t <= 9)  es = 2;
         else if (t == 10) es = 3;
         else if (t == 11) es = 4;
         else              es = 0;
         ea = (t < 3) ? t : 3;
         eb = (t < 4) ? 0 : ((t - 4 < 5) ? t - 4 : 5);
         chk("t1_state", int'(state_o), es);
         chk("t1_busy", int'(busy), int'(es >= 1 && es <= 3));
         chk("t1_done", int'(done), int'(t == 11));
         chk("t1_cnt_a", int'(cnt_a), ea);
         chk("t1_cnt_b", int'(cnt_b), eb);
      end
      wait_empty(20);

      run_seq(63, 63, 1'b0);
      chk("max_soma_hex", int'(soma), 126);
      run_seq(0, 0, 1'b0);

      // stop during RUN_B with cnt_a=4, cnt_b=2
      @(negedge clk);
      lim_a = 6'd4; lim_b = 6'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_stop_state", int'(state_o), 2);
      chk("pre_stop_cnt_b", int'(cnt_b), 2);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_state", int'(state_o), 0);
      chk("stop_cnt_a", int'(cnt_a), 4);
      chk("stop_cnt_b", int'(cnt_b), 2);
      chk("stop_soma", int'(soma), 0);
      for (int i = 0; i < 4; i++) begin
         chk("stop_no_done", int'(done), 0);
         @(negedge clk);
      end

      // back-to-back restart, plus a start pulse while busy that must be ignored
      lim_a = 6'd2; lim_b = 6'd3; start = 1'b1;
      e.cyc = cyc + 1 + 8; e.soma = 7'd5; e.a = 6'd2; e.b = 6'd3; e.hit = 1'b0;
      q.push_back(e);
      e.cyc = cyc + 1 + 14; e.soma = 7'd2; e.a = 6'd1; e.b = 6'd1; e.hit = 1'b0;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      lim_a = 6'd7; lim_b = 6'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      lim_a = 6'd1; lim_b = 6'd1; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      chk("b2b_state", int'(state_o), 1);
      chk("b2b_cnt_a", int'(cnt_a), 0);
      chk("b2b_soma", int'(soma), 0);
      wait_empty(40);

`ifdef CONT_SOMA_THRESH_EN
      thresh = 7'd10;
      run_seq(4, 6, 1'b1);
      thresh = 7'd11;
      run_seq(4, 6, 1'b0);
`else
      run_seq(4, 6, 1'b0);
`endif

      // asynchronous reset mid RUN_A
      @(negedge clk);
      lim_a = 6'd10; lim_b = 6'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_cnt_a", int'(cnt_a), 2);
      #2 clr_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state_o), 0);
      chk("async_rst_cnt_a", int'(cnt_a), 0);
      chk("async_rst_cnt_b", int'(cnt_b), 0);
      chk("async_rst_soma", int'(soma), 0);
      chk("async_rst_busy", int'(busy), 0);
      #9 clr_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_rst_state", int'(state_o), 0);
      chk("post_rst_done", int'(done), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
